// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and defaults for the bit-serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational one-bit full-subtractor cell
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, LSB first
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             a_msb;
    logic             b_msb;
    logic             cell_d;
    logic             cell_bo;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bo)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            borrow   <= 1'b0;
            a_sr     <= '0;
            b_sr     <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            diff     <= '0;
            done     <= 1'b0;
            bout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        borrow <= 1'b0;
                        cnt    <= '0;
                        diff   <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                    diff   <= {cell_d, diff[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    borrow <= cell_bo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        bout     <= cell_bo;
                        overflow <= (a_msb != b_msb) && (cell_d != a_msb);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed table-driven bench for serial_subtractor and its cell
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             overflow;

    logic fa, fb, fbin, fd, fbo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] ed;
        logic       eb;
        logic       eo;
    } vec_t;

    vec_t vecs[8];

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .bout     (bout),
        .overflow (overflow)
    );

    full_subtractor u_fs (
        .a    (fa),
        .b    (fb),
        .bin  (fbin),
        .d    (fd),
        .bout (fbo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // One full operation: start pulsed for one edge, then observe WIDTH+4 cycles.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] ed,
                          input logic eb, input logic eo, input string nm);
        int lat;
        int busy_cnt;
        int done_cnt;
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~va;
        b = ~vb;
        lat = -1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < WIDTH + 4; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) lat = k;
            end
        end
        chk({nm, " latency"}, lat, WIDTH);
        chk({nm, " busy_cycles"}, busy_cnt, WIDTH + 1);
        chk({nm, " done_count"}, done_cnt, 1);
        chk({nm, " diff"}, diff, ed);
        chk({nm, " bout"}, bout, eb);
        chk({nm, " overflow"}, overflow, eo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_done;
        int second_done;
        int done_seen;
        int r;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};
        vecs[7] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};

        // Cell truth table against integer subtraction.
        for (int i = 0; i < 8; i++) begin
            fa = i[2];
            fb = i[1];
            fbin = i[0];
            #1;
            r = int'(fa) - int'(fb) - int'(fbin);
            chk($sformatf("cell d row%0d", i), fd, r & 1);
            chk($sformatf("cell bout row%0d", i), fbo, (r < 0) ? 1 : 0);
        end

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset diff", diff, 0);
        chk("reset bout", bout, 0);
        chk("reset overflow", overflow, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].va, vecs[i].vb, vecs[i].ed, vecs[i].eb, vecs[i].eo,
                   $sformatf("vec%0d", i));

        // Reset in the middle of SHIFT aborts immediately.
        @(negedge clk);
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midop busy before reset", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midop reset busy", busy, 0);
        chk("midop reset done", done, 0);
        chk("midop reset diff", diff, 0);
        chk("midop reset bout", bout, 0);
        chk("midop reset overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < WIDTH + 4; k++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        chk("no activity after reset", done_seen, 0);
        run_op(8'd10, 8'd7, 8'h03, 1'b0, 1'b0, "after_reset");

        // Start held high; operands change during SHIFT.
        @(negedge clk);
        a = 8'd9;
        b = 8'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'd1;
        b = 8'd1;
        first_done = -1;
        second_done = -1;
        for (int k = 0; k < 2 * WIDTH + 6; k++) begin
            @(negedge clk);
            if (done && first_done < 0) begin
                first_done = k;
                chk("held first diff", diff, 8'h05);
            end else if (done && second_done < 0) begin
                second_done = k;
                chk("held second diff", diff, 8'h00);
            end
            if (k == WIDTH + 1) chk("held idle gap busy", busy, 0);
            if (k == WIDTH + 2) chk("held restart clears diff", diff, 0);
        end
        start = 1'b0;
        chk("held first latency", first_done, WIDTH);
        chk("held second latency", second_done, 2 * WIDTH + 2);
        repeat (WIDTH + 4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
